// File: rtl/rv32_pkg.sv
// Shared types for the rv32 memory-side blocks.
// Arbiter FSM states and transaction owner encoding.
package rv32_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT} arb_state_t;
  typedef enum logic {ARB_OWN_D, ARB_OWN_I} arb_owner_t;

  localparam int unsigned WSTRB_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between the data (D) and fetch (I) requesters.
// Data is favoured until it has won MAX_DATA_STREAK times in a row while fetch waits.
module mem_arb_pick
  import rv32_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic idle,
  input  logic d_valid,
  input  logic i_valid,
  output logic grant_d,
  output logic grant_i
);

  localparam int unsigned CNT_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_DATA_STREAK);

  logic [CNT_W-1:0] streak;
  logic             i_turn;

  always_comb begin
    i_turn  = i_valid && (!d_valid || (streak == STREAK_MAX));
    grant_i = idle && i_turn;
    grant_d = idle && d_valid && !i_turn;
  end

  // Only D grants made while fetch is waiting count towards the streak.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      streak <= '0;
    end else if (grant_i || (idle && !i_valid)) begin
      streak <= '0;
    end else if (grant_d && (streak != STREAK_MAX)) begin
      streak <= streak + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch (I) and the memory stage (D).
// One transaction at a time: IDLE -> REQ -> WAIT; responses route to the registered owner.
module mem_arbiter
  import rv32_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               d_req_valid,
  output logic               d_req_ready,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  input  logic [WSTRB_W-1:0] d_wstrb,
  output logic               d_rsp_valid,
  output logic [DATA_W-1:0]  d_rdata,
  input  logic               i_req_valid,
  output logic               i_req_ready,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               i_rsp_valid,
  output logic [DATA_W-1:0]  i_rdata,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic [WSTRB_W-1:0] mem_wstrb,
  input  logic               mem_rsp_valid,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               busy
);

  arb_state_t state, state_nxt;
  arb_owner_t owner;
  logic       idle;
  logic       grant_d, grant_i;
  logic       rsp_hit;

  always_comb idle = (state == ARB_IDLE);

  mem_arb_pick #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_pick (
    .clk    (clk),
    .resetn (resetn),
    .idle   (idle),
    .d_valid(d_req_valid),
    .i_valid(i_req_valid),
    .grant_d(grant_d),
    .grant_i(grant_i)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ARB_IDLE;
    else         state <= state_nxt;
  end

  // Memory responses outside WAIT are stray and never reach a requester.
  always_comb begin
    state_nxt     = state;
    rsp_hit       = (state == ARB_WAIT) && mem_rsp_valid;
    d_req_ready   = grant_d;
    i_req_ready   = grant_i;
    mem_req_valid = (state == ARB_REQ);
    busy          = (state != ARB_IDLE);
    d_rsp_valid   = rsp_hit && (owner == ARB_OWN_D);
    i_rsp_valid   = rsp_hit && (owner == ARB_OWN_I);
    d_rdata       = mem_rdata;
    i_rdata       = mem_rdata;
    unique case (state)
      ARB_IDLE: if (grant_d || grant_i) state_nxt = ARB_REQ;
      ARB_REQ:  if (mem_req_ready)      state_nxt = ARB_WAIT;
      ARB_WAIT: if (mem_rsp_valid)      state_nxt = ARB_IDLE;
      default:                          state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner     <= ARB_OWN_D;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (grant_d) begin
      owner     <= ARB_OWN_D;
      mem_we    <= d_we;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
      mem_wstrb <= d_wstrb;
    end else if (grant_i) begin
      owner     <= ARB_OWN_I;
      mem_we    <= 1'b0;
      mem_addr  <= i_addr;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter with a sparse-memory slave model.
// Expected read data comes from a reference memory updated in grant order.
module tb_mem_arbiter;

  localparam int unsigned MAXS = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        d_req_valid, d_req_ready, d_we, d_rsp_valid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        i_req_valid, i_req_ready, i_rsp_valid;
  logic [31:0] i_addr, i_rdata;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_DATA_STREAK(MAXS)
  ) dut (
    .clk(clk), .resetn(resetn),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_rsp_valid(i_rsp_valid), .i_rdata(i_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; int gap; } d_item_t;
  typedef struct { logic [31:0] addr; int gap; } i_item_t;
  typedef struct { logic is_wr; logic [31:0] data; } rsp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; logic is_i; } mreq_t;

  d_item_t     d_q[$];
  i_item_t     i_q[$];
  rsp_t        exp_d[$], exp_i[$];
  mreq_t       exp_m[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  int n_cmp = 0, n_err = 0, cyc = 0;
  int rdy_pct = 100, lat_min = 1, lat_max = 1;
  bit stray_en = 0, fixed_mode = 0;
  int rsp_cyc = -1;
  logic d_hs = 1'b0, i_hs = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got an event expected none (cycle %0d)", nm, cyc);
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // D requester: holds valid until accepted, then takes the next queued item.
  initial begin
    d_item_t it;
    d_req_valid = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    forever begin
      @(posedge clk); #1;
      if (d_req_valid && d_hs) d_req_valid = 0;
      if (!d_req_valid && d_q.size() != 0) begin
        if (d_q[0].gap > 0) d_q[0].gap = d_q[0].gap - 1;
        else begin
          it = d_q.pop_front();
          d_req_valid = 1; d_we = it.we; d_addr = it.addr; d_wdata = it.wdata; d_wstrb = it.wstrb;
        end
      end
    end
  end

  initial begin
    i_item_t it;
    i_req_valid = 0; i_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (i_req_valid && i_hs) i_req_valid = 0;
      if (!i_req_valid && i_q.size() != 0) begin
        if (i_q[0].gap > 0) i_q[0].gap = i_q[0].gap - 1;
        else begin
          it = i_q.pop_front();
          i_req_valid = 1; i_addr = it.addr;
        end
      end
    end
  end

  // Memory slave: one outstanding access, response lat_min..lat_max cycles after accept.
  initial begin
    logic [31:0] pend;
    int cnt;
    cnt = 0; pend = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (resetn && mem_req_valid && mem_req_ready) begin
        if (mem_we) begin
          slv_mem[mem_addr] = merge(slv_rd(mem_addr), mem_wdata, mem_wstrb);
          pend = $urandom;
        end else pend = slv_rd(mem_addr);
        cnt = $urandom_range(lat_max, lat_min);
      end
      @(posedge clk); #1;
      mem_rsp_valid = 0;
      mem_rdata = $urandom;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin mem_rsp_valid = 1; mem_rdata = pend; end
      end else if (stray_en && $urandom_range(7) == 0) mem_rsp_valid = 1;
      mem_req_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  // Monitor: arbitration rule, request stability and response scoreboard.
  initial begin
    int    i_wait, gnt_cyc;
    bit    txn;
    logic  exp_gd, exp_gi;
    rsp_t  r;
    mreq_t m;
    i_wait = 0; gnt_cyc = -1; txn = 0;
    forever begin
      @(negedge clk);
      d_hs = d_req_valid && d_req_ready;
      i_hs = i_req_valid && i_req_ready;
      if (!resetn) begin
        chk("reset_ctl", {mem_req_valid, mem_we, d_rsp_valid, i_rsp_valid, busy}, 0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_wdata", mem_wdata, 0);
        chk("reset_wstrb", mem_wstrb, 0);
        exp_d.delete(); exp_i.delete(); exp_m.delete();
        i_wait = 0; txn = 0; gnt_cyc = -1; rsp_cyc = -1;
        d_hs = 0; i_hs = 0;
      end else begin
        chk("busy", busy, txn);
        exp_gi = !txn && i_req_valid && (!d_req_valid || i_wait >= MAXS);
        exp_gd = !txn && d_req_valid && !exp_gi;
        chk("grant", {d_req_ready, i_req_ready}, {exp_gd, exp_gi});
        if (d_hs || i_hs) begin
          if (fixed_mode && rsp_cyc >= 0) chk("regrant_gap", cyc - rsp_cyc, 1);
          gnt_cyc = cyc;
          txn = 1;
        end
        if (d_hs) begin
          if (i_req_valid) i_wait++;
          exp_m.push_back('{d_we, d_addr, d_wdata, d_wstrb, 1'b0});
          if (d_we) begin
            ref_mem[d_addr] = merge(ref_rd(d_addr), d_wdata, d_wstrb);
            exp_d.push_back('{1'b1, 32'h0});
          end else exp_d.push_back('{1'b0, ref_rd(d_addr)});
        end
        if (i_hs) begin
          i_wait = 0;
          exp_m.push_back('{1'b0, i_addr, 32'h0, 4'h0, 1'b1});
          exp_i.push_back('{1'b0, ref_rd(i_addr)});
        end
        if (!i_req_valid) i_wait = 0;
        if (mem_req_valid) begin
          if (exp_m.size() == 0) fail_evt("mem_req_unexpected");
          else begin
            m = exp_m[0];
            chk("mem_we", mem_we, m.we);
            chk("mem_addr", mem_addr, m.addr);
            if (m.we) begin
              chk("mem_wdata", mem_wdata, m.wdata);
              chk("mem_wstrb", mem_wstrb, m.wstrb);
            end else if (m.is_i) chk("mem_wstrb_i", mem_wstrb, 0);
            if (mem_req_ready) void'(exp_m.pop_front());
          end
        end
        if (d_rsp_valid && i_rsp_valid) fail_evt("rsp_both_sides");
        if (d_rsp_valid || i_rsp_valid) begin
          if (fixed_mode) chk("rsp_latency", cyc - gnt_cyc, 2);
          rsp_cyc = cyc;
          txn = 0;
        end
        if (d_rsp_valid) begin
          if (exp_d.size() == 0) fail_evt("d_rsp_stray");
          else begin
            r = exp_d.pop_front();
            if (!r.is_wr) chk("d_rdata", d_rdata, r.data);
          end
        end
        if (i_rsp_valid) begin
          if (exp_i.size() == 0) fail_evt("i_rsp_stray");
          else begin
            r = exp_i.pop_front();
            chk("i_rdata", i_rdata, r.data);
          end
        end
      end
    end
  end

  task automatic drain(input int max_cyc, input string nm);
    int k;
    k = 0;
    while ((d_q.size() != 0 || i_q.size() != 0 || d_req_valid || i_req_valid || busy ||
            exp_d.size() != 0 || exp_i.size() != 0) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k >= max_cyc) begin
      n_err++;
      $display("FAIL drain_%s: got %0d cycles without completion expected under %0d", nm, k, max_cyc);
    end
  endtask

  initial begin
    int k;
    resetn = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1;

    // Single D read with 1-cycle memory
    ref_mem[32'h100] = 32'hDEADBEEF;
    slv_mem[32'h100] = 32'hDEADBEEF;
    rsp_cyc = -1; fixed_mode = 1;
    d_q.push_back('{1'b0, 32'h100, 32'h0, 4'h0, 0});
    drain(50, "t1");

    // D and I continuously valid: D x4 then I, responses routed per owner
    rsp_cyc = -1;
    for (int n = 0; n < 14; n++)
      d_q.push_back('{1'($urandom_range(1)), 32'h100 + (32'($urandom_range(7)) << 2), $urandom, 4'($urandom_range(15)), 0});
    for (int n = 0; n < 4; n++)
      i_q.push_back('{32'h100 + (32'($urandom_range(7)) << 2), 0});
    drain(400, "t3");
    fixed_mode = 0;

    // Partial write then read back
    d_q.push_back('{1'b1, 32'h200, 32'h12345678, 4'b0011, 0});
    d_q.push_back('{1'b0, 32'h200, 32'h0, 4'h0, 0});
    i_q.push_back('{32'h200, 3});
    drain(100, "t5");

    // Memory stalls in REQ
    rdy_pct = 0;
    d_q.push_back('{1'b1, 32'h300, 32'hCAFEF00D, 4'b1100, 0});
    i_q.push_back('{32'h304, 0});
    repeat (8) @(negedge clk);
    chk("stall_busy", busy, 1);
    chk("stall_no_grant", {d_req_ready, i_req_ready}, 0);
    rdy_pct = 100;
    drain(100, "t4");

    // Reset while waiting for a read; the late response must be dropped
    lat_min = 3; lat_max = 3;
    d_q.push_back('{1'b0, 32'h400, 32'h0, 4'h0, 0});
    k = 0;
    do begin @(negedge clk); k++; end while (!(mem_req_valid && mem_req_ready) && k < 50);
    chk("reset_test_accept", {31'h0, k < 50}, 1);
    @(posedge clk); #1 resetn = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 resetn = 1;
    @(negedge clk);
    chk("stray_after_reset", {d_rsp_valid, i_rsp_valid, busy}, 0);
    lat_min = 1; lat_max = 1;
    d_q.push_back('{1'b0, 32'h404, 32'h0, 4'h0, 0});
    drain(50, "t6");

    // Random traffic with stalls, variable latency and stray responses
    rdy_pct = 60; lat_min = 1; lat_max = 3; stray_en = 1;
    for (int n = 0; n < 150; n++)
      d_q.push_back('{1'($urandom_range(1)), 32'h1000 + (32'($urandom_range(15)) << 2), $urandom,
                      4'($urandom_range(15)), int'($urandom_range(3))});
    for (int n = 0; n < 60; n++)
      i_q.push_back('{32'h1000 + (32'($urandom_range(15)) << 2), int'($urandom_range(4))});
    drain(5000, "random");
    stray_en = 0;
    repeat (3) @(negedge clk);
    finish_run();
  end

  initial begin
    repeat (40000) @(posedge clk);
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: got cycle %0d expected the run to end earlier", cyc);
    finish_run();
  end

endmodule
